// File: rtl/rdma_rc_pkg.sv
// ---------------------------------------------------------------------------
// rdma_rc_pkg
//
// Definitions shared by the RDMA RC transmit PDU builder and the receive-side
// PDU parser. Both ends of the link must agree on these encodings.
//
// Contents:
//   - QP state encodings, matching the QP FSM.
//   - Opcode class boundaries (data, control, reserved).
//   - Header field offsets and a packed header type whose field order is the
//     on-wire bit order of the 64-bit header beat.
//   - Transmit FSM state type.
// ---------------------------------------------------------------------------
package rdma_rc_pkg;

  // Encodings driven by the QP state machine. Codes not listed here are
  // never produced by that FSM, and every checker treats them as
  // "not allowed to transmit".
  typedef enum logic [2:0] {
    QP_RESET = 3'b000,
    QP_INIT  = 3'b001,
    QP_RTR   = 3'b010,
    QP_RTS   = 3'b011,
    QP_ERROR = 3'b111
  } qp_state_e;

  localparam int OPCODE_W = 8;
  localparam int QPN_W    = 16;
  localparam int PSN_W    = 24;
  localparam int LEN_W    = 8;
  localparam int HDR_W    = 64;

  // Opcode classes. Data opcodes may only go out once the QP is in RTS.
  // Control opcodes are used for connection bring-up and are only sent in
  // RTR. The upper half of the opcode space is reserved.
  localparam logic [OPCODE_W-1:0] OPC_DATA_MAX = 8'h1F;
  localparam logic [OPCODE_W-1:0] OPC_CTRL_MIN = 8'h20;
  localparam logic [OPCODE_W-1:0] OPC_CTRL_MAX = 8'h7F;
  localparam logic [OPCODE_W-1:0] OPC_RSVD_MIN = 8'h80;

  // Bit offsets of the header fields inside the header beat. The parser
  // slices the header with these, so they must not drift from the struct
  // below.
  localparam int HDR_OPCODE_LSB = 56;
  localparam int HDR_RSVD_LSB   = 48;
  localparam int HDR_QPN_LSB    = 32;
  localparam int HDR_PSN_LSB    = 8;
  localparam int HDR_LEN_LSB    = 0;

  // Header beat, MSB first: opcode, reserved zero byte, remote QPN, PSN,
  // payload beat count.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [7:0]          rsvd;
    logic [QPN_W-1:0]    qpn;
    logic [PSN_W-1:0]    psn;
    logic [LEN_W-1:0]    len;
  } pdu_hdr_t;

  // Transmit sequencing: waiting for a request, presenting the header,
  // passing payload through.
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HDR  = 2'd1,
    TX_PAY  = 2'd2
  } tx_state_e;

  // Assembles a header beat. The reserved byte is always driven to zero so
  // the receiver can treat a non-zero value as corruption.
  function automatic pdu_hdr_t pack_header(
    input logic [OPCODE_W-1:0] opcode,
    input logic [QPN_W-1:0]    qpn,
    input logic [PSN_W-1:0]    psn,
    input logic [LEN_W-1:0]    len
  );
    pdu_hdr_t h;
    h.opcode = opcode;
    h.rsvd   = 8'h00;
    h.qpn    = qpn;
    h.psn    = psn;
    h.len    = len;
    return h;
  endfunction

endpackage

// File: rtl/rdma_rc_opcode_check.sv
// ---------------------------------------------------------------------------
// rdma_rc_opcode_check
//
// Purely combinational legality check of an opcode against the QP state. The
// transmit builder uses it to reject send requests, and the receive path uses
// the same module to drop PDUs that arrive in the wrong state.
//
// Ports:
//   qp_state  in   3  current QP state (rdma_rc_pkg::qp_state_e encoding)
//   opcode    in   8  opcode under test
//   legal     out  1  opcode may be sent/received in this QP state
// ---------------------------------------------------------------------------
module rdma_rc_opcode_check
  import rdma_rc_pkg::*;
(
  input  logic [2:0]          qp_state,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                legal
);

  logic is_data;
  logic is_ctrl;
  logic is_rsvd;

  // Classify the opcode. Data opcodes start at zero, so only their upper
  // bound needs a compare.
  always_comb begin
    is_data = (opcode <= OPC_DATA_MAX);
    is_ctrl = (opcode >= OPC_CTRL_MIN) && (opcode <= OPC_CTRL_MAX);
    is_rsvd = (opcode >= OPC_RSVD_MIN);
  end

  // Data traffic is only allowed in RTS and control traffic only in RTR.
  // Every other state, including unused encodings, rejects everything.
  // Reserved opcodes are rejected explicitly so the rule still holds if the
  // class boundaries are ever widened.
  always_comb begin
    legal = 1'b0;
    if (!is_rsvd) begin
      if (qp_state == QP_RTS) begin
        legal = is_data;
      end else if (qp_state == QP_RTR) begin
        legal = is_ctrl;
      end
    end
  end

endmodule

// File: rtl/rdma_rc_pdu_builder.sv
// ---------------------------------------------------------------------------
// rdma_rc_pdu_builder
//
// Transmit-side PDU assembler for the RDMA RC datapath. It accepts a send
// request from the QP scheduler and rejects it if the opcode is not allowed in
// the current QP state. An accepted request is stamped with the remote QPN and
// the next PSN. The block then streams one registered header beat followed by
// req_len payload beats. Payload beats pass through combinationally from the
// payload source to the physical layer.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   qp_state     in   3         QP state, sampled only when a request is accepted
//   remote_qpn   in   QPN       destination QPN, sampled only at accept
//   psn_load     in   1         load the PSN counter from psn_init (idle only)
//   psn_init     in   PSN       PSN load value
//   req_valid    in   1         send request valid
//   req_ready    out  1         request accepted when req_valid and req_ready
//   req_opcode   in   OPCODE    requested opcode
//   req_len      in   LEN       payload beats after the header
//   pay_data     in   DATA      payload beat
//   pay_valid    in   1         payload beat valid
//   pay_ready    out  1         payload beat consumed
//   pdu_data     out  DATA      PDU beat toward the physical layer
//   pdu_valid    out  1         PDU beat valid
//   pdu_ready    in   1         downstream accepts the beat
//   pdu_last     out  1         final beat of the PDU
//   req_err      out  1         one-cycle pulse after a rejected request
//   tx_done      out  1         one-cycle pulse after the last beat was sent
//   next_psn     out  PSN       PSN that the next PDU will carry
// ---------------------------------------------------------------------------
module rdma_rc_pdu_builder
  import rdma_rc_pkg::*;
#(
  parameter int QPN_WIDTH    = 16,
  parameter int PSN_WIDTH    = 24,
  parameter int OPCODE_WIDTH = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              qp_state,
  input  logic [QPN_WIDTH-1:0]    remote_qpn,
  input  logic                    psn_load,
  input  logic [PSN_WIDTH-1:0]    psn_init,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OPCODE_WIDTH-1:0] req_opcode,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [DATA_WIDTH-1:0]   pay_data,
  input  logic                    pay_valid,
  output logic                    pay_ready,
  output logic [DATA_WIDTH-1:0]   pdu_data,
  output logic                    pdu_valid,
  input  logic                    pdu_ready,
  output logic                    pdu_last,
  output logic                    req_err,
  output logic                    tx_done,
  output logic [PSN_WIDTH-1:0]    next_psn
);

  tx_state_e             state_q, state_d;
  pdu_hdr_t              hdr_q, hdr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PSN_WIDTH-1:0]  psn_q, psn_d;
  logic                  req_err_q, req_err_d;
  logic                  tx_done_q, tx_done_d;
  logic                  alive_q;
  logic                  req_legal;
  logic                  final_beat;

  // The same checker the receive path uses, so both directions always agree
  // on which opcodes are allowed in which QP state.
  rdma_rc_opcode_check u_opcode_check (
    .qp_state (qp_state),
    .opcode   (req_opcode),
    .legal    (req_legal)
  );

  // State and datapath registers. alive_q is low throughout reset and for
  // the first edge after release. It keeps req_ready low while in reset
  // without feeding rst_n into the datapath logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      hdr_q     <= '0;
      cnt_q     <= '0;
      psn_q     <= '0;
      req_err_q <= 1'b0;
      tx_done_q <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      cnt_q     <= cnt_d;
      psn_q     <= psn_d;
      req_err_q <= req_err_d;
      tx_done_q <= tx_done_d;
      alive_q   <= 1'b1;
    end
  end

  // Next-state and output decode.
  //
  // IDLE: a PSN load takes priority and closes the request port for that
  // cycle. A request is accepted only when no load is pending. The header is
  // built from the current PSN counter, so the counter only needs to move
  // once the PDU has actually left.
  //
  // HDR: the registered header is held until downstream takes it. A
  // zero-length PDU ends here.
  //
  // PAY: payload is a straight combinational pass-through, so stalls on
  // either side propagate immediately. The counter tracks the beats still
  // owed, and pdu_last is raised when one beat remains.
  //
  // Completion from either state advances the PSN, which wraps naturally at
  // the counter width, and raises tx_done for one cycle.
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    cnt_d      = cnt_q;
    psn_d      = psn_q;
    req_err_d  = 1'b0;
    tx_done_d  = 1'b0;
    final_beat = 1'b0;
    req_ready  = 1'b0;
    pay_ready  = 1'b0;
    pdu_valid  = 1'b0;
    pdu_last   = 1'b0;
    pdu_data   = '0;

    case (state_q)
      TX_IDLE: begin
        req_ready = alive_q && !psn_load;
        if (psn_load) begin
          psn_d = psn_init;
        end else if (req_valid && alive_q) begin
          if (req_legal) begin
            hdr_d   = pack_header(req_opcode, remote_qpn, psn_q, req_len);
            state_d = TX_HDR;
          end else begin
            req_err_d = 1'b1;
          end
        end
      end

      TX_HDR: begin
        pdu_valid = 1'b1;
        pdu_data  = DATA_WIDTH'(hdr_q);
        pdu_last  = (hdr_q.len == '0);
        if (pdu_ready) begin
          if (hdr_q.len == '0) begin
            state_d    = TX_IDLE;
            final_beat = 1'b1;
          end else begin
            state_d = TX_PAY;
            cnt_d   = hdr_q.len;
          end
        end
      end

      TX_PAY: begin
        pdu_valid = pay_valid;
        pdu_data  = pay_data;
        pay_ready = pdu_ready;
        pdu_last  = (cnt_q == LEN_WIDTH'(1));
        if (pay_valid && pdu_ready) begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d    = TX_IDLE;
            final_beat = 1'b1;
          end
        end
      end

      default: begin
        state_d = TX_IDLE;
      end
    endcase

    if (final_beat) begin
      psn_d     = psn_q + PSN_WIDTH'(1);
      tx_done_d = 1'b1;
    end
  end

  // Status outputs come straight from their registers, so both pulses land
  // in the cycle after the event that caused them.
  always_comb begin
    req_err  = req_err_q;
    tx_done  = tx_done_q;
    next_psn = psn_q;
  end

endmodule

// File: tb/tb_rdma_rc_pdu_builder.sv
// ---------------------------------------------------------------------------
// tb_rdma_rc_pdu_builder
//
// Self-checking bench for rdma_rc_pdu_builder. Inputs are driven just after
// the falling edge and outputs are sampled 1 ns later, well before the next
// rising edge. The reference PSN and the opcode legality rule are kept here as
// plain values. Each PDU is checked beat by beat against an expected queue
// (header followed by random payload).
// ---------------------------------------------------------------------------
module tb_rdma_rc_pdu_builder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  qp_state;
  logic [15:0] remote_qpn;
  logic        psn_load;
  logic [23:0] psn_init;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_opcode;
  logic [7:0]  req_len;
  logic [63:0] pay_data;
  logic        pay_valid;
  logic        pay_ready;
  logic [63:0] pdu_data;
  logic        pdu_valid;
  logic        pdu_ready;
  logic        pdu_last;
  logic        req_err;
  logic        tx_done;
  logic [23:0] next_psn;

  int          test_count;
  int          fail_count;
  logic [23:0] model_psn;

  typedef struct {
    logic [2:0] qp;
    logic [7:0] op;
    logic [7:0] len;
    bit         legal;
  } vec_t;

  vec_t vecs[13];

  rdma_rc_pdu_builder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .qp_state   (qp_state),
    .remote_qpn (remote_qpn),
    .psn_load   (psn_load),
    .psn_init   (psn_init),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_len    (req_len),
    .pay_data   (pay_data),
    .pay_valid  (pay_valid),
    .pay_ready  (pay_ready),
    .pdu_data   (pdu_data),
    .pdu_valid  (pdu_valid),
    .pdu_ready  (pdu_ready),
    .pdu_last   (pdu_last),
    .req_err    (req_err),
    .tx_done    (tx_done),
    .next_psn   (next_psn)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Legality written directly from the opcode-class rules.
  function automatic bit refLegal(input logic [2:0] qp, input logic [7:0] op);
    int unsigned o;
    o = op;
    if (o >= 128) return 1'b0;
    if (qp == 3'b011) return (o < 32);
    if (qp == 3'b010) return (o >= 32);
    return 1'b0;
  endfunction

  // Loads the PSN counter while idle and checks that the request port closes.
  task automatic loadPsn(input logic [23:0] v);
    psn_load = 1'b1;
    psn_init = v;
    #1;
    checkOutput("req_ready_during_load", 64'(req_ready), 64'd0);
    @(negedge clk);
    psn_load  = 1'b0;
    model_psn = v;
    #1;
    checkOutput("psn_loaded", 64'(next_psn), 64'(v));
  endtask

  // Issues one request and follows it to completion or rejection. Random
  // stalls on pdu_ready and pay_valid come from stall (percent). err_mid
  // moves the QP to ERROR after the first payload beat.
  task automatic applyStimulus(input logic [2:0] qp, input logic [7:0] op, input logic [7:0] len,
                               input bit legal, input int stall, input bit err_mid);
    logic [63:0] exp_beats[$];
    logic [63:0] hdr;
    logic [15:0] qpn;
    int          beats;
    int          cycles;
    qpn        = 16'($urandom);
    qp_state   = qp;
    remote_qpn = qpn;
    req_opcode = op;
    req_len    = len;
    req_valid  = 1'b1;
    pdu_ready  = 1'b0;
    pay_valid  = 1'b0;
    #1;
    checkOutput("req_ready_idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid  = 1'b0;
    req_opcode = 8'($urandom);
    req_len    = 8'($urandom);
    #1;
    if (!legal) begin
      checkOutput("req_err_pulse", 64'(req_err), 64'd1);
      checkOutput("no_pdu_on_err", 64'(pdu_valid), 64'd0);
      checkOutput("psn_kept_on_err", 64'(next_psn), 64'(model_psn));
      @(negedge clk);
      #1;
      checkOutput("req_err_clear", 64'(req_err), 64'd0);
      checkOutput("no_pdu_after_err", 64'(pdu_valid), 64'd0);
      return;
    end
    checkOutput("no_err_on_legal", 64'(req_err), 64'd0);
    hdr = {op, 8'h00, qpn, model_psn, len};
    exp_beats.push_back(hdr);
    for (int i = 0; i < int'(len); i++) exp_beats.push_back({$urandom, $urandom});
    beats  = 0;
    cycles = 0;
    while (beats <= int'(len) && cycles < 500) begin
      pdu_ready  = ($urandom_range(99) >= stall);
      pay_valid  = ($urandom_range(99) >= stall);
      pay_data   = (beats >= 1) ? exp_beats[beats] : {$urandom, $urandom};
      remote_qpn = 16'($urandom);
      #1;
      if (beats == 0) begin
        checkOutput("hdr_valid", 64'(pdu_valid), 64'd1);
        checkOutput("hdr_stable", pdu_data, hdr);
        checkOutput("pay_ready_in_hdr", 64'(pay_ready), 64'd0);
      end else begin
        checkOutput("pay_valid_pass", 64'(pdu_valid), 64'(pay_valid));
        checkOutput("pay_ready_pass", 64'(pay_ready), 64'(pdu_ready));
      end
      if (pdu_valid && pdu_ready) begin
        checkOutput("beat_data", pdu_data, exp_beats[beats]);
        checkOutput("beat_last", 64'(pdu_last), 64'(beats == int'(len)));
        beats++;
        if (err_mid && beats == 2) qp_state = 3'b111;
      end
      @(negedge clk);
      cycles++;
    end
    checkOutput("pdu_complete", 64'(beats > int'(len)), 64'd1);
    pdu_ready = 1'b0;
    pay_valid = 1'b0;
    #1;
    model_psn = model_psn + 24'd1;
    checkOutput("tx_done_pulse", 64'(tx_done), 64'd1);
    checkOutput("next_psn_inc", 64'(next_psn), 64'(model_psn));
    checkOutput("no_extra_beat", 64'(pdu_valid), 64'd0);
    checkOutput("req_ready_after", 64'(req_ready), 64'd1);
    @(negedge clk);
    #1;
    checkOutput("tx_done_clear", 64'(tx_done), 64'd0);
  endtask

  // Checks that every output is at its reset value.
  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    checkOutput({tag, "_pdu_valid"}, 64'(pdu_valid), 64'd0);
    checkOutput({tag, "_pdu_data"}, pdu_data, 64'd0);
    checkOutput({tag, "_pdu_last"}, 64'(pdu_last), 64'd0);
    checkOutput({tag, "_pay_ready"}, 64'(pay_ready), 64'd0);
    checkOutput({tag, "_req_err"}, 64'(req_err), 64'd0);
    checkOutput({tag, "_tx_done"}, 64'(tx_done), 64'd0);
    checkOutput({tag, "_next_psn"}, 64'(next_psn), 64'd0);
  endtask

  initial begin
    logic [2:0] rqp;
    logic [7:0] rop;
    int         sel;

    test_count = 0;
    fail_count = 0;
    model_psn  = 24'd0;

    vecs[0]  = '{3'b010, 8'h11, 8'd0, 1'b0};
    vecs[1]  = '{3'b010, 8'h20, 8'd0, 1'b1};
    vecs[2]  = '{3'b011, 8'h80, 8'd3, 1'b0};
    vecs[3]  = '{3'b001, 8'h04, 8'd1, 1'b0};
    vecs[4]  = '{3'b111, 8'h20, 8'd1, 1'b0};
    vecs[5]  = '{3'b111, 8'h04, 8'd0, 1'b0};
    vecs[6]  = '{3'b011, 8'h1F, 8'd1, 1'b1};
    vecs[7]  = '{3'b010, 8'h7F, 8'd3, 1'b1};
    vecs[8]  = '{3'b011, 8'h20, 8'd2, 1'b0};
    vecs[9]  = '{3'b000, 8'h00, 8'd0, 1'b0};
    vecs[10] = '{3'b010, 8'h1F, 8'd1, 1'b0};
    vecs[11] = '{3'b010, 8'hFF, 8'd0, 1'b0};
    vecs[12] = '{3'b011, 8'h00, 8'd0, 1'b1};

    rst_n      = 1'b0;
    qp_state   = 3'b000;
    remote_qpn = 16'h0;
    psn_load   = 1'b0;
    psn_init   = 24'h0;
    req_valid  = 1'b0;
    req_opcode = 8'h0;
    req_len    = 8'h0;
    pay_data   = 64'h0;
    pay_valid  = 1'b0;
    pdu_ready  = 1'b0;

    repeat (3) @(negedge clk);
    req_valid = 1'b1;
    #1;
    checkReset("reset");
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    $display("[TB] first PDU after PSN load");
    loadPsn(24'h000100);
    applyStimulus(3'b011, 8'h04, 8'd2, 1'b1, 0, 1'b0);
    checkOutput("psn_after_first", 64'(next_psn), 64'h000101);

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].qp, vecs[i].op, vecs[i].len, vecs[i].legal, 0, 1'b0);
    end

    $display("[TB] PSN wrap");
    loadPsn(24'hFFFFFF);
    applyStimulus(3'b011, 8'h03, 8'd1, 1'b1, 0, 1'b0);
    applyStimulus(3'b011, 8'h03, 8'd0, 1'b1, 0, 1'b0);
    checkOutput("psn_wrapped", 64'(next_psn), 64'h000001);

    $display("[TB] stalls and QP error mid-payload");
    applyStimulus(3'b011, 8'h01, 8'd5, 1'b1, 50, 1'b0);
    applyStimulus(3'b011, 8'h02, 8'd4, 1'b1, 20, 1'b1);

    $display("[TB] load and request in the same cycle");
    psn_load   = 1'b1;
    psn_init   = 24'h00ABCD;
    qp_state   = 3'b011;
    req_valid  = 1'b1;
    req_opcode = 8'h05;
    req_len    = 8'd1;
    #1;
    checkOutput("load_wins_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    psn_load  = 1'b0;
    model_psn = 24'h00ABCD;
    #1;
    checkOutput("load_wins_no_pdu", 64'(pdu_valid), 64'd0);
    checkOutput("load_wins_psn", 64'(next_psn), 64'h00ABCD);
    applyStimulus(3'b011, 8'h05, 8'd1, 1'b1, 0, 1'b0);

    $display("[TB] randomized requests");
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      rqp = (sel < 4) ? 3'b011 : (sel < 8) ? 3'b010 : (sel == 8) ? 3'b111 : 3'($urandom_range(0, 1));
      rop = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 127));
      applyStimulus(rqp, rop, 8'($urandom_range(0, 7)), refLegal(rqp, rop), $urandom_range(0, 60), 1'b0);
    end

    $display("[TB] reset during payload");
    qp_state   = 3'b011;
    req_opcode = 8'h03;
    req_len    = 8'd6;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    pdu_ready = 1'b1;
    pay_valid = 1'b1;
    pay_data  = 64'hDEAD_BEEF_0123_4567;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("mid_pay_ready", 64'(pay_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    @(negedge clk);
    rst_n     = 1'b1;
    pdu_ready = 1'b0;
    pay_valid = 1'b0;
    model_psn = 24'd0;
    @(negedge clk);
    #1;
    checkOutput("post_reset_idle_ready", 64'(req_ready), 64'd1);
    checkOutput("post_reset_no_beat", 64'(pdu_valid), 64'd0);
    checkOutput("post_reset_no_done", 64'(tx_done), 64'd0);
    applyStimulus(3'b010, 8'h21, 8'd1, 1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
